ps2_kbd_rx: RTL and testbench

- PS/2 keyboard receiver. Oversamples the keyboard's ps2_clk/ps2_data lines in the system clock domain and deserialises 11-bit frames.
- Validates each frame and queues the received scan codes in a small FIFO.
- Presents codes to a consumer through a ready/nextdata_n pop handshake.
- Sits between the board PS/2 pins (or the keyboard behavioural model in simulation) and the scan-code decoder logic.

---
 rtl/ps2_kbd_pkg.sv | 21 ++
 rtl/ps2_kbd_fifo.sv | 51 +++++
 rtl/ps2_kbd_rx.sv | 115 +++++++++++
 tb/tb_ps2_kbd_rx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard receiver: frame layout, counter width
// and common scan codes, plus the frame validity rule.
package ps2_kbd_pkg;

    localparam int unsigned FRAME_BITS   = 11;
    localparam int unsigned BIT_START    = 0;
    localparam int unsigned BIT_DATA_LSB = 1;
    localparam int unsigned BIT_PARITY   = 9;
    localparam int unsigned BIT_STOP     = 10;
    localparam int unsigned CNT_W        = $clog2(FRAME_BITS);

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_KEY_A = 8'h1C;
    localparam logic [7:0] SC_KEY_S = 8'h1B;

    // Start low, stop high, odd parity over data plus parity bit.
    function automatic logic frame_ok(input logic [FRAME_BITS-2:0] bits, input logic stop);
        return !bits[BIT_START] && stop && (^bits[BIT_PARITY:BIT_DATA_LSB]);
    endfunction

endpackage

// File: rtl/ps2_kbd_fifo.sv
// Scan-code FIFO: circular buffer with an extra pointer MSB for full/empty,
// head entry presented combinationally.
module ps2_kbd_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic [7:0]  r_mem [DEPTH];
    logic        w_full;
    logic        w_empty;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (i_push && !w_full) begin
                r_mem[r_wr[AW-1:0]] <= i_wdata;
                r_wr                <= r_wr + (AW+1)'(1);
            end
            if (i_pop && !w_empty) begin
                r_rd <= r_rd + (AW+1)'(1);
            end
        end
    end

    assign o_rdata = r_mem[r_rd[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deserialises 11-bit frames
// and queues valid scan codes. Optional partial-frame timeout: PS2_KBD_TIMEOUT_EN.
module ps2_kbd_rx
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ps2_kbd_rx: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [2:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [CNT_W-1:0]      r_cnt;
    logic [FRAME_BITS-2:0] r_buf;
    logic                  r_overflow;

    logic       w_fe;
    logic       w_bit;
    logic       w_last;
    logic       w_frame_ok;
    logic       w_abort;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    assign w_fe       = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit      = r_data_sync[1];
    assign w_last     = (r_cnt == CNT_W'(BIT_STOP));
    assign w_frame_ok = w_fe && w_last && frame_ok(r_buf, w_bit);

`ifdef PS2_KBD_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] r_idle;

    // Idle counter saturates at the limit so the abort condition stays stable.
    always_ff @(posedge clk) begin
        if (rst || w_fe) begin
            r_idle <= '0;
        end else if (r_idle != IDLE_W'(TIMEOUT_CYCLES)) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    assign w_abort = (r_cnt != '0) && (r_idle == IDLE_W'(TIMEOUT_CYCLES));
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_buf <= '0;
        end else if (w_fe) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_buf[r_cnt] <= w_bit;
                r_cnt        <= r_cnt + CNT_W'(1);
            end
        end else if (w_abort) begin
            r_cnt <= '0;
            r_buf <= '0;
        end
    end

    // Full is judged on pre-cycle pointers, so a same-cycle pop does not save the byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_frame_ok && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    ps2_kbd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_frame_ok),
        .i_pop   (!nextdata_n),
        .i_wdata (r_buf[BIT_PARITY-1:BIT_DATA_LSB]),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign data     = w_head;
    assign ready    = !w_empty;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed plus randomized bench for ps2_kbd_rx with a queue-based reference model.
module tb_ps2_kbd_rx;
    import ps2_kbd_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    int         total = 0;
    int         bad = 0;
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

`ifdef PS2_KBD_TIMEOUT_EN
    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
`else
    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH)) dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare visible state against the model: occupancy, head code, overflow.
    task automatic check_state(input string tag);
        check({tag, ".ready"}, 32'(ready), 32'(mq.size() != 0));
        if (mq.size() != 0) check({tag, ".data"}, 32'(data), 32'(mq[0]));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    // Drives the first nbits of a frame as a keyboard would: data changes while clock is high.
    task automatic send_bits(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                             input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (6) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_code(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        send_bits(code, bad_par, bad_stop, 11);
        if (!bad_par && !bad_stop) begin
            if (mq.size() < DEPTH) mq.push_back(code);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic pop_one(input string tag);
        check_state(tag);
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    initial begin
        logic [7:0] seq [6];
        seq = '{SC_KEY_A, SC_BREAK, SC_KEY_A, SC_KEY_S, SC_BREAK, SC_KEY_S};

        do_reset();
        check("rst.ready", 32'(ready), 32'd0);
        check("rst.ovf", 32'(overflow), 32'd0);
        check("rst.data", 32'(data), 32'h00);

        send_code(SC_KEY_A, 0, 0);
        check("first.ready", 32'(ready), 32'd1);
        check("first.data", 32'(data), 32'h1C);
        check("first.ovf", 32'(overflow), 32'd0);
        pop_one("first.pop");
        check("first.empty", 32'(ready), 32'd0);

        foreach (seq[i]) send_code(seq[i], 0, 0);
        check("seq.count", 32'(mq.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("seq.order", 32'(data), 32'(seq[i]));
            pop_one("seq.pop");
        end
        check("seq.drained", 32'(ready), 32'd0);

        send_code(SC_KEY_A, 1, 0);
        check("badpar.ready", 32'(ready), 32'd0);
        send_code(SC_KEY_A, 0, 1);
        check("badstop.ready", 32'(ready), 32'd0);

        for (int i = 1; i <= 9; i++) begin
            send_code(8'(i), 0, 0);
            check("ovf.flag", 32'(overflow), 32'(i == 9));
        end
        for (int i = 1; i <= 8; i++) begin
            check("ovf.drain", 32'(data), 32'(i));
            pop_one("ovf.pop");
        end
        check("ovf.empty", 32'(ready), 32'd0);
        check("ovf.sticky", 32'(overflow), 32'd1);
        do_reset();
        check("ovf.cleared", 32'(overflow), 32'd0);

        send_bits(8'h55, 0, 0, 5);
        do_reset();
        check("midrst.ready", 32'(ready), 32'd0);
        send_code(SC_KEY_S, 0, 0);
        check("midrst.data", 32'(data), 32'h1B);
        pop_one("midrst.pop");
        check("midrst.single", 32'(ready), 32'd0);

`ifdef PS2_KBD_TIMEOUT_EN
        send_bits(8'hA5, 0, 0, 4);
        repeat (150) @(negedge clk);
        send_code(SC_KEY_A, 0, 0);
        check("tmo.data", 32'(data), 32'h1C);
        pop_one("tmo.pop");
        check("tmo.single", 32'(ready), 32'd0);
`endif

        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [7:0] code;
            int         kind;
            int         pops;
            code = 8'($urandom);
            kind = int'($urandom_range(0, 7));
            send_code(code, kind == 0, kind == 1);
            check_state("rnd.after_frame");
            pops = int'($urandom_range(0, 2));
            for (int p = 0; p < pops; p++) pop_one("rnd.pop");
        end
        while (mq.size() != 0) pop_one("rnd.drain");
        check_state("rnd.final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
